adsr_env: RTL and testbench



---
 rtl/adsr_env.sv | 128 ++++++++++++
 tb/tb_adsr_env.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adsr_env.sv
// ADSR envelope generator: prescaled tick, gate-edge FSM, saturating 16-bit level.
// Optional ADSR_EXP_DECAY_EN adds level>>6 to the decay/release decrement.
module adsr_env #(
    parameter int TICK_DIV = 256,
    parameter int LVL_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       adsr_ai,
    input  logic [7:0]       adsr_di,
    input  logic [7:0]       adsr_s,
    input  logic [7:0]       adsr_ri,
    input  logic             trig,
    input  logic             mute,
    output logic [7:0]       env_out,
    output logic [2:0]       env_state,
    output logic             env_active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = '1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             gate_q;

    logic             tick, rise, fall;
    logic [LVL_W-1:0] step_a, step_d, step_r, tgt;
    logic [LVL_W:0]   sum_a, dec_d, dec_r;
    logic             atk_hit, dec_hit, rel_hit;

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign rise  = trig & ~gate_q;
    assign fall  = ~trig & gate_q;

    always_comb begin
        step_a = {4'b0, adsr_ai, 4'b0};
        step_d = {4'b0, adsr_di, 4'b0};
        step_r = {4'b0, adsr_ri, 4'b0};
        tgt    = {adsr_s, adsr_s};
        sum_a  = {1'b0, level_q} + {1'b0, step_a};
`ifdef ADSR_EXP_DECAY_EN
        dec_d  = {1'b0, step_d} + {7'b0, level_q[15:6]};
        dec_r  = {1'b0, step_r} + {7'b0, level_q[15:6]};
`else
        dec_d  = {1'b0, step_d};
        dec_r  = {1'b0, step_r};
`endif
        atk_hit = (adsr_ai == 8'd0) || (sum_a >= {1'b0, LVL_MAX});
        // level - dec <= T rewritten as level <= dec + T to avoid underflow
        dec_hit = (adsr_di == 8'd0)
               || ({2'b0, level_q} <= ({1'b0, dec_d} + {2'b0, tgt}));
        rel_hit = (adsr_ri == 8'd0) || ({1'b0, level_q} <= dec_r);
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise) begin
            state_d = S_ATTACK;
        end else if (fall) begin
            if (state_q == S_ATTACK || state_q == S_DECAY
                || state_q == S_SUSTAIN)
                state_d = S_RELEASE;
        end else if (tick) begin
            unique case (state_q)
                S_ATTACK: begin
                    if (atk_hit) begin
                        level_d = LVL_MAX;
                        state_d = S_DECAY;
                    end else begin
                        level_d = sum_a[LVL_W-1:0];
                    end
                end
                S_DECAY: begin
                    if (dec_hit) begin
                        level_d = tgt;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = level_q - dec_d[LVL_W-1:0];
                    end
                end
                S_SUSTAIN: level_d = tgt;
                S_RELEASE: begin
                    if (rel_hit) begin
                        level_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        level_d = level_q - dec_r[LVL_W-1:0];
                    end
                end
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            gate_q     <= 1'b0;
            level_q    <= '0;
            state_q    <= S_IDLE;
            env_out    <= 8'h00;
            env_state  <= 3'd0;
            env_active <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            gate_q     <= trig;
            level_q    <= level_d;
            state_q    <= state_d;
            env_out    <= mute ? 8'h00 : level_q[LVL_W-1:LVL_W-8];
            env_state  <= state_d;
            env_active <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_adsr_env.sv
// Bench for adsr_env: two instances (TICK_DIV=4 and 1) on shared inputs,
// checked against a cycle model through a scoreboard queue.
module tb_adsr_env;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ai = 8'h10, di = 8'hFF, s = 8'h80, ri = 8'h00;
    logic       trig = 1'b1, mute = 1'b0;

    logic [7:0] env [2];
    logic [2:0] sts [2];
    logic       act [2];

    int n_tot = 0;
    int n_bad = 0;

    typedef struct {
        int inst;
        int env;
        int st;
    } exp_t;
    exp_t sbq[$];

    int m_lvl [2] = '{0, 0};
    int m_st  [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};
    int m_env [2] = '{0, 0};
    bit m_gq  [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    adsr_env #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .adsr_ai(ai), .adsr_di(di),
        .adsr_s(s), .adsr_ri(ri), .trig(trig), .mute(mute),
        .env_out(env[0]), .env_state(sts[0]), .env_active(act[0])
    );

    adsr_env #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .adsr_ai(ai), .adsr_di(di),
        .adsr_s(s), .adsr_ri(ri), .trig(trig), .mute(mute),
        .env_out(env[1]), .env_state(sts[1]), .env_active(act[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decr(input int r, input int lvl);
        int d;
        d = r * 16;
`ifdef ADSR_EXP_DECAY_EN
        d = d + lvl / 64;
`endif
        return d;
    endfunction

    task automatic model_step(input int k, input int div);
        int lvl, st, nl, ns, t, d, sum;
        bit tk, up, dn;
        if (rst) begin
            m_lvl[k] = 0; m_st[k] = 0; m_cnt[k] = 0;
            m_gq[k] = 1'b0; m_env[k] = 0;
            return;
        end
        lvl = m_lvl[k];
        st  = m_st[k];
        tk  = (m_cnt[k] == div - 1);
        m_cnt[k] = tk ? 0 : m_cnt[k] + 1;
        up  = trig && !m_gq[k];
        dn  = !trig && m_gq[k];
        nl  = lvl;
        ns  = st;
        t   = int'(s) * 257;
        if (up) begin
            ns = 1;
        end else if (dn) begin
            if (st >= 1 && st <= 3) ns = 4;
        end else if (tk) begin
            case (st)
                1: begin
                    sum = lvl + int'(ai) * 16;
                    if (ai == 0 || sum >= 65535) begin
                        nl = 65535; ns = 2;
                    end else nl = sum;
                end
                2: begin
                    d = decr(int'(di), lvl);
                    if (di == 0 || lvl - d <= t) begin
                        nl = t; ns = 3;
                    end else nl = lvl - d;
                end
                3: nl = t;
                4: begin
                    d = decr(int'(ri), lvl);
                    if (ri == 0 || lvl <= d) begin
                        nl = 0; ns = 0;
                    end else nl = lvl - d;
                end
                default: nl = lvl;
            endcase
        end
        m_env[k] = mute ? 0 : lvl / 256;
        m_lvl[k] = nl;
        m_st[k]  = ns;
        m_gq[k]  = trig;
    endtask

    always @(posedge clk) begin
        model_step(0, 4);
        sbq.push_back('{0, m_env[0], m_st[0]});
        model_step(1, 1);
        sbq.push_back('{1, m_env[1], m_st[1]});
    end

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("sb_env%0d", e.inst), int'(env[e.inst]), e.env);
            chk($sformatf("sb_st%0d", e.inst), int'(sts[e.inst]), e.st);
            chk($sformatf("sb_act%0d", e.inst), int'(act[e.inst]),
                (e.st != 0) ? 1 : 0);
        end
    end

    task automatic wait_st(input int k, input int st, input int lim);
        int n = 0;
        while (int'(sts[k]) != st && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_st%0d_%0d", k, st), int'(sts[k]), st);
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("rst_env", int'(env[0]), 0);
            chk("rst_st", int'(sts[0]), 0);
            chk("rst_act", int'(act[0]), 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("atk_start", int'(sts[0]), 1);

        wait_st(0, 2, 1500);
        chk("atk_peak", int'(env[0]), 8'hFF);
        wait_st(0, 3, 100);
        repeat (2) @(negedge clk);
        chk("sus_80", int'(env[0]), 8'h80);
        s = 8'h40;
        repeat (10) @(negedge clk);
        chk("sus_40", int'(env[0]), 8'h40);

        trig = 1'b0;
        @(negedge clk);
        chk("rel_st", int'(sts[0]), 4);
        wait_st(0, 0, 20);
        chk("rel_act", int'(act[0]), 0);

        s = 8'h80; ri = 8'h10; trig = 1'b1;
        wait_st(0, 3, 2000);
        trig = 1'b0;
        repeat (128) @(negedge clk);
        trig = 1'b1;
        repeat (2) @(negedge clk);
        chk("retrig_st", int'(sts[0]), 1);
        chk("no_drop", (env[0] >= 8'h5F) ? 1 : 0, 1);
        mute = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("mute_env", int'(env[0]), 0);
            chk("mute_st", int'(sts[0]), 1);
        end
        mute = 1'b0;
        @(negedge clk);
        chk("unmute", (env[0] >= 8'h60) ? 1 : 0, 1);

        trig = 1'b0; ri = 8'h00;
        repeat (8) @(negedge clk);
        chk("idle1", int'(sts[1]), 0);
        ai = 8'h01; trig = 1'b1;
        repeat (257) @(negedge clk);
        chk("col_pre", int'(u_dut1.level_q), 16'h1000);
        trig = 1'b0;
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        chk("col_hold", int'(u_dut1.level_q), 16'h1000);
        chk("col_st", int'(sts[1]), 1);
        @(negedge clk);
        chk("col_step", int'(u_dut1.level_q), 16'h1010);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
